ann_coef_arbiter: RTL and testbench
===================================

Name: ann_coef_arbiter

Overview:
- Shares one single-port classifier coefficient ROM between the three ANN scale engines (23x23, 19x19, 17x17).
- Each engine requests a burst of consecutive coefficient words. The arbiter grants one engine at a time, round-robin, then drives the ROM read port for that burst.
- Returned words are steered to the granted engine with a per-engine valid, and a done pulse marks the last word.
- Sits between the three ANN engines and the coefficient ROM. It runs under the top-level controller, which clears it through iFlush.

Parameters:
- ADDR_W, 12, coefficient ROM address width.
- DATA_W, 16, coefficient word width.
- LEN_W, 7, burst length field width.

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous reset, active-high.
- iFlush  in  1  synchronous abort/clear (driven from iFinish_Set_OM).
- iReq  in  3  burst request; bit0=23x23, bit1=19x19, bit2=17x17.
- iAddr_23 / iAddr_19 / iAddr_17  in  ADDR_W each  burst base address per requester.
- iLen_23 / iLen_19 / iLen_17  in  LEN_W each  burst length per requester; 0 means 2^LEN_W words.
- iMem_data  in  DATA_W  ROM read data, valid one cycle after oMem_rd.
- oMem_rd  out  1  ROM read strobe.
- oMem_addr  out  ADDR_W  ROM read address.
- oGrant  out  3  one-hot grant, registered.
- oData  out  DATA_W  equals iMem_data (combinational pass-through).
- oValid  out  3  per-requester data valid, registered.
- oDone  out  3  one-cycle pulse on the last word of a burst.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (iReset=1):
  - All outputs are 0 (oGrant, oMem_rd, oMem_addr, oValid, oDone, oBusy); oData follows iMem_data.
  - State is IDLE and the round-robin pointer ptr is 0.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - iReq is sampled only in IDLE.
  - If iReq != 0, the winner is the first set bit scanning ptr, ptr+1, ptr+2 (mod 3).
  - The winner's base address and length are latched into addr_cnt and len_cnt, and the state goes to BURST.
  - oGrant, oMem_rd=1 and oMem_addr=base all appear in the first BURST cycle.
- BURST:
  - One read is issued per cycle; oMem_addr increments by 1 and wraps modulo 2^ADDR_W.
  - len_cnt decrements each cycle.
  - After the L-th read (L = len, or 2^LEN_W when len=0), the state goes to DRAIN and oMem_rd drops.
- Data return: oValid[g] is the registered copy of (oMem_rd and oGrant[g]), so it is high in the cycle iMem_data is valid.
- DRAIN:
  - The last word arrives; oValid[g]=1 and oDone[g]=1 in this cycle only.
  - Next state is IDLE; oGrant is 0 from IDLE onward; ptr = (g+1) mod 3.
- Latency, with the request seen in IDLE at cycle t:
  - Grant and first read at t+1.
  - First word at t+2.
  - Last word and oDone at t+1+L.
  - IDLE at t+2+L.
  - Minimum gap between bursts is 1 IDLE cycle.
- Requester rule:
  - Hold iReq until oGrant is seen.
  - Deassert iReq no later than the cycle after oDone; otherwise the engine re-enters arbitration.
  - iReq changes during BURST or DRAIN are ignored.
- Base address and length: iAddr/iLen are sampled only at grant, so later changes do not affect the active burst.
- Simultaneous requests are resolved by ptr only. A requester that is not granted waits at most two bursts.
- iFlush:
  - Takes priority over everything except iReset.
  - Next cycle: IDLE, oGrant=0, oMem_rd=0, oValid=0; no oDone is emitted for the aborted burst.
  - ptr is unchanged, and an in-flight ROM word is discarded.
- iReset during a burst: the full reset values apply on the next edge.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority 23x23 > 19x19 > 17x17. ptr is neither maintained nor used, and all other timing is unchanged.
- Undefined (default): round-robin arbitration as specified above.

Test Plan:
- Reset, then iReq=3'b001, iAddr_23=0x010, iLen_23=4:
  - oGrant=001 one cycle later.
  - oMem_addr 0x010..0x013.
  - oValid[0] on 4 consecutive cycles, oDone[0] on the 4th.
  - IDLE 6 cycles after the request.
- iReq=3'b111 held, each requester dropping its request the cycle after its own oDone (ptr=0): grant order 23, 19, 17. Then reassert all → order 23, 19, 17 again (ptr back to 0).
- iLen_19=0, iAddr_19=0xFF0:
  - 128 reads; oMem_addr wraps 0xFFF → 0x000.
  - Exactly 128 oValid[1] pulses, then one oDone[1].
- iFlush asserted on the 3rd BURST cycle of a 10-word burst:
  - Next cycle oGrant=0, oMem_rd=0, oValid=0.
  - No oDone; ptr unchanged, so the same requester wins again if still requesting.
- iAddr/iLen changed during BURST: the addresses issued continue from the latched base. Requester 0 holding iReq after oDone: a second burst is granted to it after one IDLE cycle only when no other request is pending (round-robin).
- With ARB_FIXED_PRIO_EN, iReq=3'b110 continuously: 19x19 wins every burst.

Source files
------------

// File: rtl/ann_coef_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ann_coef_arbiter
// Purpose  : Round-robin burst arbiter sharing one coefficient ROM between the
//            23x23, 19x19 and 17x17 ANN scale engines.
//            Define ARB_FIXED_PRIO_EN for fixed priority 23x23 > 19x19 > 17x17.
// Revision : 1.0 - initial release
// ============================================================================
module ann_coef_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 7
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iFlush,
  input  logic [2:0]        iReq,
  input  logic [ADDR_W-1:0] iAddr_23,
  input  logic [ADDR_W-1:0] iAddr_19,
  input  logic [ADDR_W-1:0] iAddr_17,
  input  logic [LEN_W-1:0]  iLen_23,
  input  logic [LEN_W-1:0]  iLen_19,
  input  logic [LEN_W-1:0]  iLen_17,
  input  logic [DATA_W-1:0] iMem_data,
  output logic              oMem_rd,
  output logic [ADDR_W-1:0] oMem_addr,
  output logic [2:0]        oGrant,
  output logic [DATA_W-1:0] oData,
  output logic [2:0]        oValid,
  output logic [2:0]        oDone,
  output logic              oBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        grant_nxt;
  logic              rd_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LEN_W:0]    len_cnt, len_nxt;
  logic [2:0]        valid_nxt;
  logic [2:0]        done_nxt;
  logic [2:0]        win;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W:0]    len_ld;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = 3'b000;
    if (iReq[0])      win = 3'b001;
    else if (iReq[1]) win = 3'b010;
    else if (iReq[2]) win = 3'b100;
  end
`else
  logic [1:0] ptr, ptr_nxt;

  // Scan order starts at ptr and wraps modulo 3.
  always_comb begin
    win = 3'b000;
    case (ptr)
      2'd1: begin
        if (iReq[1])      win = 3'b010;
        else if (iReq[2]) win = 3'b100;
        else if (iReq[0]) win = 3'b001;
      end
      2'd2: begin
        if (iReq[2])      win = 3'b100;
        else if (iReq[0]) win = 3'b001;
        else if (iReq[1]) win = 3'b010;
      end
      default: begin
        if (iReq[0])      win = 3'b001;
        else if (iReq[1]) win = 3'b010;
        else if (iReq[2]) win = 3'b100;
      end
    endcase
  end
`endif

  always_comb begin
    sel_addr = iAddr_23;
    sel_len  = iLen_23;
    if (win[1]) begin
      sel_addr = iAddr_19;
      sel_len  = iLen_19;
    end else if (win[2]) begin
      sel_addr = iAddr_17;
      sel_len  = iLen_17;
    end
  end

  // A zero length field encodes the maximum burst of 2^LEN_W words.
  assign len_ld = (sel_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, sel_len};

  always_comb begin
    state_nxt = state;
    grant_nxt = oGrant;
    rd_nxt    = oMem_rd;
    addr_nxt  = oMem_addr;
    len_nxt   = len_cnt;
    valid_nxt = {3{oMem_rd}} & oGrant;
    done_nxt  = 3'b000;
`ifndef ARB_FIXED_PRIO_EN
    ptr_nxt   = ptr;
`endif
    case (state)
      IDLE: begin
        if (iReq != 3'b000) begin
          state_nxt = BURST;
          grant_nxt = win;
          rd_nxt    = 1'b1;
          addr_nxt  = sel_addr;
          len_nxt   = len_ld;
        end
      end
      BURST: begin
        if (len_cnt == (LEN_W+1)'(1)) begin
          state_nxt = DRAIN;
          rd_nxt    = 1'b0;
          done_nxt  = oGrant;
        end else begin
          addr_nxt = oMem_addr + ADDR_W'(1);
          len_nxt  = len_cnt - (LEN_W+1)'(1);
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
        grant_nxt = 3'b000;
`ifndef ARB_FIXED_PRIO_EN
        if (oGrant[0])      ptr_nxt = 2'd1;
        else if (oGrant[1]) ptr_nxt = 2'd2;
        else                ptr_nxt = 2'd0;
`endif
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 3'b000;
        rd_nxt    = 1'b0;
      end
    endcase
    // Abort drops any in-flight word and leaves the pointer untouched.
    if (iFlush) begin
      state_nxt = IDLE;
      grant_nxt = 3'b000;
      rd_nxt    = 1'b0;
      valid_nxt = 3'b000;
      done_nxt  = 3'b000;
`ifndef ARB_FIXED_PRIO_EN
      ptr_nxt   = ptr;
`endif
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state     <= IDLE;
      oGrant    <= 3'b000;
      oMem_rd   <= 1'b0;
      oMem_addr <= '0;
      len_cnt   <= '0;
      oValid    <= 3'b000;
      oDone     <= 3'b000;
`ifndef ARB_FIXED_PRIO_EN
      ptr       <= 2'd0;
`endif
    end else begin
      state     <= state_nxt;
      oGrant    <= grant_nxt;
      oMem_rd   <= rd_nxt;
      oMem_addr <= addr_nxt;
      len_cnt   <= len_nxt;
      oValid    <= valid_nxt;
      oDone     <= done_nxt;
`ifndef ARB_FIXED_PRIO_EN
      ptr       <= ptr_nxt;
`endif
    end
  end

  assign oBusy = (state != IDLE);
  assign oData = iMem_data;

endmodule
`default_nettype wire

// File: tb/tb_ann_coef_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ann_coef_arbiter
// Purpose  : Directed self-checking bench for ann_coef_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ann_coef_arbiter;

  logic        iClk = 1'b0;
  logic        iReset, iFlush;
  logic [2:0]  iReq;
  logic [11:0] iAddr_23, iAddr_19, iAddr_17;
  logic [6:0]  iLen_23, iLen_19, iLen_17;
  logic [15:0] iMem_data = 16'h0000;
  logic        oMem_rd;
  logic [11:0] oMem_addr;
  logic [2:0]  oGrant;
  logic [15:0] oData;
  logic [2:0]  oValid;
  logic [2:0]  oDone;
  logic        oBusy;

  int checks = 0;
  int errors = 0;

`ifdef ARB_FIXED_PRIO_EN
  localparam int W_FL = 0;
  localparam int W_T5 = 0;
  localparam int W_P2 = 1;
`else
  localparam int W_FL = 2;
  localparam int W_T5 = 1;
  localparam int W_P2 = 2;
`endif

  ann_coef_arbiter #(.ADDR_W(12), .DATA_W(16), .LEN_W(7)) dut (
    .iClk(iClk), .iReset(iReset), .iFlush(iFlush), .iReq(iReq),
    .iAddr_23(iAddr_23), .iAddr_19(iAddr_19), .iAddr_17(iAddr_17),
    .iLen_23(iLen_23), .iLen_19(iLen_19), .iLen_17(iLen_17),
    .iMem_data(iMem_data), .oMem_rd(oMem_rd), .oMem_addr(oMem_addr),
    .oGrant(oGrant), .oData(oData), .oValid(oValid), .oDone(oDone),
    .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  function automatic logic [15:0] rom(input logic [11:0] a);
    return {4'hA, a} ^ 16'h0F0F;
  endfunction

  // ROM: data for the address strobed in one cycle appears the next.
  always @(posedge iClk) iMem_data <= oMem_rd ? rom(oMem_addr) : 16'h0000;

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] addr_of(input int g);
    return (g == 0) ? iAddr_23 : (g == 1) ? iAddr_19 : iAddr_17;
  endfunction

  function automatic logic [6:0] len_of(input int g);
    return (g == 0) ? iLen_23 : (g == 1) ? iLen_19 : iLen_17;
  endfunction

  // Called in the IDLE cycle where the request is visible; returns in the
  // IDLE cycle after the burst.
  task automatic burst(input int g, input bit chg);
    logic [11:0] base, a;
    logic [2:0]  oh;
    int          len;
    base = addr_of(g);
    len  = (len_of(g) == 7'd0) ? 128 : int'(len_of(g));
    oh   = 3'b001 << g;
    tick;
    chk("grant", oGrant, oh);
    chk("rd_first", oMem_rd, 1);
    chk("addr_first", oMem_addr, base);
    chk("busy", oBusy, 1);
    chk("valid_first", oValid, 0);
    if (chg) begin
      iAddr_23 = 12'h700; iAddr_19 = 12'h710; iAddr_17 = 12'h720;
      iLen_23  = 7'd2;    iLen_19  = 7'd2;    iLen_17  = 7'd2;
    end
    for (int i = 1; i < len; i++) begin
      tick;
      a = base + 12'(i);
      chk("addr", oMem_addr, a);
      chk("rd", oMem_rd, 1);
      chk("valid", oValid, oh);
      chk("data", oData, rom(a - 12'd1));
      chk("done_early", oDone, 0);
    end
    tick;
    chk("rd_drain", oMem_rd, 0);
    chk("valid_last", oValid, oh);
    chk("done_last", oDone, oh);
    chk("data_last", oData, rom(base + 12'(len - 1)));
    chk("grant_drain", oGrant, oh);
    tick;
    chk("busy_idle", oBusy, 0);
    chk("grant_idle", oGrant, 0);
    chk("valid_idle", oValid, 0);
    chk("done_idle", oDone, 0);
  endtask

  initial begin
    iReset = 1'b1; iFlush = 1'b0; iReq = 3'b000;
    iAddr_23 = '0; iAddr_19 = '0; iAddr_17 = '0;
    iLen_23 = '0;  iLen_19 = '0;  iLen_17 = '0;
    tick; tick;
    chk("rst_grant", oGrant, 0);
    chk("rst_rd", oMem_rd, 0);
    chk("rst_addr", oMem_addr, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_done", oDone, 0);
    chk("rst_busy", oBusy, 0);
    iReset = 1'b0;

    // Single 4-word burst from 23x23.
    iReq = 3'b001; iAddr_23 = 12'h010; iLen_23 = 7'd4;
    burst(0, 1'b0);
    iReq = 3'b000;

    // Reset mid-burst clears everything, including the pointer.
    iReq = 3'b001;
    tick;
    chk("mid_grant", oGrant, 3'b001);
    iReset = 1'b1; iReq = 3'b000;
    tick;
    chk("mrst_grant", oGrant, 0);
    chk("mrst_rd", oMem_rd, 0);
    chk("mrst_addr", oMem_addr, 0);
    chk("mrst_busy", oBusy, 0);
    iReset = 1'b0;
    tick;
    chk("mrst_valid", oValid, 0);

    // All three requesting from ptr=0: order 23, 19, 17, twice.
    iAddr_23 = 12'h100; iLen_23 = 7'd2;
    iAddr_19 = 12'h200; iLen_19 = 7'd3;
    iAddr_17 = 12'h300; iLen_17 = 7'd1;
    for (int r = 0; r < 2; r++) begin
      iReq = 3'b111;
      burst(0, 1'b0); iReq[0] = 1'b0;
      burst(1, 1'b0); iReq[1] = 1'b0;
      burst(2, 1'b0); iReq[2] = 1'b0;
    end

    // Maximum length burst with address wrap.
    iLen_19 = 7'd0; iAddr_19 = 12'hFF0;
    iReq = 3'b010;
    burst(1, 1'b0);
    iReq = 3'b000;

    // Flush on the third BURST cycle of a 10-word burst.
    iAddr_23 = 12'h400; iLen_23 = 7'd10;
    iAddr_17 = 12'h300; iLen_17 = 7'd10;
    iReq = 3'b101;
    tick;
    chk("fl_grant", oGrant, 3'b001 << W_FL);
    tick;
    tick;
    chk("fl_addr3", oMem_addr, addr_of(W_FL) + 12'd2);
    iFlush = 1'b1;
    tick;
    iFlush = 1'b0;
    chk("fl_grant0", oGrant, 0);
    chk("fl_rd0", oMem_rd, 0);
    chk("fl_valid0", oValid, 0);
    chk("fl_done0", oDone, 0);
    chk("fl_busy0", oBusy, 0);
    burst(W_FL, 1'b0);
    iReq = 3'b000;

    // Mid-burst base/len change ignored; held 23x23 request yields to 19x19.
    iAddr_23 = 12'h050; iLen_23 = 7'd3;
    iAddr_19 = 12'h060; iLen_19 = 7'd3;
    iReq = 3'b011;
    burst(0, 1'b1);
    burst(W_T5, 1'b0);
    iReq = 3'b001;
    burst(0, 1'b0);
    iReq = 3'b000;

    // 19x19 and 17x17 requesting continuously.
    iReq = 3'b110;
    burst(1, 1'b0);
    burst(W_P2, 1'b0);
    burst(1, 1'b0);
    iReq = 3'b000;
    tick;
    chk("end_busy", oBusy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
